wb_arbiter: RTL

- Write-port front end of the 32x32 register file: owns the regfile's single write port (`o_rd_wren`, `o_rd_addr`, `o_rd_data` → `i_rd_wren`, `i_rd_addr`, `i_rd_data`).
- Merges two sources:
  - in-order pipeline writeback, which has absolute priority;
  - out-of-order long-latency results (load miss, mul/div) via valid/ready into a small FIFO.
- Keeps a 32-bit pending-register scoreboard so issue logic can stall on RAW/WAW hazards against outstanding long-latency ops.

---
 rtl/wbarb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wbarb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wbarb_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_CUT
  } wr_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t holding queued long-latency results.
module wb_fifo
  import wbarb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  wb_req_t                  i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output wb_req_t                  o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback over queued long-latency
// results, plus pending-register scoreboard. Optional macro: WBARB_CUTTHRU_EN.
module wb_arbiter
  import wbarb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_wren,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_ll_issue,
  input  logic [4:0]  i_ll_issue_rd,
  output logic        o_issue_stall,
  input  logic        i_ll_valid,
  output logic        o_ll_ready,
  input  logic [4:0]  i_ll_rd,
  input  logic [31:0] i_ll_data,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_pending,
  output logic        o_spurious
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REGS-1:0] r_pending;
  logic                r_spurious;

  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  wb_req_t             w_head;
  wb_req_t             w_push_data;
  wr_src_e             w_src;
  logic                w_wb_sel;
  logic                w_accept;
  logic                w_cut_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_cut;
  logic                w_clr_valid;
  logic [REG_AW-1:0]   w_clr_rd;

  assign o_ll_ready = ~i_rst & (w_count != CW'(FIFO_DEPTH));
  assign w_accept   = i_ll_valid & o_ll_ready;
  assign w_wb_sel   = i_wb_wren & (i_wb_addr != '0);

`ifdef WBARB_CUTTHRU_EN
  assign w_cut_ok = w_accept & (i_ll_rd != '0);
`else
  assign w_cut_ok = 1'b0;
`endif

  always_comb begin
    w_src = SRC_NONE;
    if (i_rst)         w_src = SRC_NONE;
    else if (w_wb_sel) w_src = SRC_WB;
    else if (!w_empty) w_src = SRC_FIFO;
    else if (w_cut_ok) w_src = SRC_CUT;
  end

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = '0;
    o_rd_data = '0;
    case (w_src)
      SRC_WB: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_wb_addr;
        o_rd_data = i_wb_data;
      end
      SRC_FIFO: begin
        o_rd_wren = 1'b1;
        o_rd_addr = w_head.rd;
        o_rd_data = w_head.data;
      end
      SRC_CUT: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_ll_rd;
        o_rd_data = i_ll_data;
      end
      default: ;
    endcase
  end

  assign w_pop       = (w_src == SRC_FIFO);
  assign w_cut       = (w_src == SRC_CUT);
  assign w_push      = w_accept & (i_ll_rd != '0) & ~w_cut & ~w_full;
  assign w_push_data = '{rd: i_ll_rd, data: i_ll_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign w_clr_valid = w_pop | w_cut;
  assign w_clr_rd    = w_pop ? w_head.rd : i_ll_rd;

  assign o_issue_stall = i_ll_issue & r_pending[i_ll_issue_rd];

  assign o_rs1_busy = (i_rs1_addr != '0) & r_pending[i_rs1_addr]
                    & ~(w_clr_valid & (w_clr_rd == i_rs1_addr));
  assign o_rs2_busy = (i_rs2_addr != '0) & r_pending[i_rs2_addr]
                    & ~(w_clr_valid & (w_clr_rd == i_rs2_addr));

  // Clear before set: a new issue to a register that is completing this cycle
  // is only possible when it was not pending, so the set must win.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr_valid) w_pending_nxt[w_clr_rd] = 1'b0;
    if (i_ll_issue && (i_ll_issue_rd != '0) && !o_issue_stall)
      w_pending_nxt[i_ll_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending  <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if ((w_push || w_cut) && !r_pending[i_ll_rd]) r_spurious <= 1'b1;
    end
  end

  assign o_pending  = r_pending;
  assign o_spurious = r_spurious;

endmodule
